stepper_phase_driver: RTL

Clocked, parametrised successor to the asynchronous STEP/DIR stepper phase driver. It samples the step and dir lines synchronously and drives a 4-coil unipolar/bipolar phase pattern. Half-step and full-step modes are selectable at run time. It adds an enable, an idle hold-current cutoff and a signed position counter for the smart-home actuator controllers (blinds, valves).

---
 rtl/stepper_phase_driver.sv | 120 ++++++++++++
 1 files changed

// File: rtl/stepper_phase_driver.sv
// Clocked STEP/DIR stepper phase driver: synchronised step/dir inputs, half/full-step
// sequencing, idle hold-current cutoff and a signed half-step position counter.
module stepper_phase_driver #(
  parameter int SYNC_STAGES    = 2,
  parameter int IDLE_TIMEOUT   = 1000000,
  parameter int POS_WIDTH      = 16,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic                 dir,
  input  logic                 enable,
  input  logic                 half_step,
  output logic [3:0]           out,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_ack,
  output logic                 idle
);

  localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_TIMEOUT);

  logic [SS-1:0]        step_sync_q, step_sync_d;
  logic [SS-1:0]        dir_sync_q, dir_sync_d;
  logic                 step_dly_q, step_dly_d;
  logic [2:0]           index_q, index_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic [3:0]           out_q, out_d;
  logic                 ack_q, ack_d;
  logic                 idle_q, idle_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 step_edge, accept, double_move;
  logic [2:0]           idx_delta;
  logic [POS_WIDTH-1:0] pos_delta;

  function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    phase_pattern = 4'b1000;
      3'd1:    phase_pattern = 4'b1100;
      3'd2:    phase_pattern = 4'b0100;
      3'd3:    phase_pattern = 4'b0110;
      3'd4:    phase_pattern = 4'b0010;
      3'd5:    phase_pattern = 4'b0011;
      3'd6:    phase_pattern = 4'b0001;
      default: phase_pattern = 4'b1001;
    endcase
  endfunction

  always_comb begin
    step_sync_d = {step_sync_q[SS-2:0], step};
    dir_sync_d  = {dir_sync_q[SS-2:0], dir};
    step_dly_d  = step_sync_q[SS-1];
    step_edge   = step_sync_q[SS-1] & ~step_dly_q;
    accept      = step_edge & enable;

    // Full-step from an even (single-coil) index only moves one half-step to realign.
    double_move = !half_step && index_q[0];
    idx_delta   = double_move ? 3'd2 : 3'd1;
    pos_delta   = double_move ? POS_WIDTH'(2) : POS_WIDTH'(1);

    index_d = index_q;
    pos_d   = pos_q;
    if (accept) begin
      if (dir_sync_q[SS-1]) begin
        index_d = index_q + idx_delta;
        pos_d   = pos_q + pos_delta;
      end else begin
        index_d = index_q - idx_delta;
        pos_d   = pos_q - pos_delta;
      end
    end
    ack_d = accept;

    if (!enable || accept) begin
      cnt_d  = '0;
      idle_d = 1'b0;
    end else begin
      cnt_d  = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
      idle_d = idle_q | ((IDLE_TIMEOUT != 0) && (cnt_d == CNT_MAX));
    end

    // Uses next idle so the coils drop on the same edge idle rises.
    out_d = 4'b0000;
    if (enable && !idle_d) begin
      out_d = phase_pattern(index_q) ^ {4{OUT_ACTIVE_LOW}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_sync_q <= '0;
      dir_sync_q  <= '0;
      step_dly_q  <= 1'b0;
      index_q     <= 3'd0;
      pos_q       <= '0;
      out_q       <= 4'b0000;
      ack_q       <= 1'b0;
      idle_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      step_sync_q <= step_sync_d;
      dir_sync_q  <= dir_sync_d;
      step_dly_q  <= step_dly_d;
      index_q     <= index_d;
      pos_q       <= pos_d;
      out_q       <= out_d;
      ack_q       <= ack_d;
      idle_q      <= idle_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out      = out_q;
  assign position = pos_q;
  assign step_ack = ack_q;
  assign idle     = idle_q;

endmodule
